// File: rtl/jtag_tap_gen.sv
// jtag_tap_gen: IEEE 1149.1 TAP controller with a parameterised IR width,
// IDCODE value and N user data-register chains.
// Owns the 16-state TAP FSM, the IR, the IDCODE and BYPASS registers, and
// the TDO mux that is registered on the falling edge of TCK.
// Optional build macro: JTAG_TAP_IR_STATUS_EN. When it is defined, the
// ir_status_i port exists and is captured into the upper IR bits on CAP_IR.
// Parameter constraints: IR_LEN >= 3; IDCODE_VAL[0] = 1; 1 <= N_CHAIN <= 16;
// the range OP_USER0..OP_USER0+N_CHAIN-1 excludes OP_IDCODE and all-ones.
module jtag_tap_gen #(
  parameter int                IR_LEN     = 5,
  parameter logic [31:0]       IDCODE_VAL = 32'h149511c3,
  parameter int                N_CHAIN    = 4,
  parameter logic [IR_LEN-1:0] OP_IDCODE  = 5'h01,
  parameter logic [IR_LEN-1:0] OP_USER0   = 5'h10
) (
  input  logic               tck_pad_i,
  input  logic               trst_pad_i,
  input  logic               tms_pad_i,
  input  logic               tdi_pad_i,
  output logic               tdo_pad_o,
  output logic               tdo_padoe_o,
  output logic               tdo_o,
  input  logic [N_CHAIN-1:0] chain_tdi_i,
  output logic [N_CHAIN-1:0] chain_sel_o,
  output logic [IR_LEN-1:0]  ir_o,
  output logic [3:0]         state_o,
  output logic               test_logic_reset_o,
  output logic               run_test_idle_o,
  output logic               capture_dr_o,
  output logic               shift_dr_o,
  output logic               pause_dr_o,
  output logic               update_dr_o
`ifdef JTAG_TAP_IR_STATUS_EN
  ,
  input  logic [IR_LEN-3:0]  ir_status_i
`endif
);

  // State encoding matches the classic TAP codes so state_o can be decoded
  // directly by downstream logic and debuggers.
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e         state_q, state_d;
  logic [IR_LEN-1:0]  ir_shift_q, ir_shift_d;
  logic [IR_LEN-1:0]  ir_q, ir_d;
  logic [31:0]        idcode_q, idcode_d;
  logic               bypass_q, bypass_d;
  logic [N_CHAIN-1:0] chain_sel_q, chain_sel_d;
  logic               tdo_q, tdo_d;
  logic               tdo_oe_q, tdo_oe_d;

  logic [IR_LEN-1:0]  ir_capture;
  logic               idcode_sel;

  // Value parallel-loaded into the IR shift register in CAP_IR. The two
  // fixed LSBs (01) are what IEEE 1149.1 requires for IR integrity checks.
`ifdef JTAG_TAP_IR_STATUS_EN
  assign ir_capture = {ir_status_i, 2'b01};
`else
  assign ir_capture = {{(IR_LEN-2){1'b0}}, 2'b01};
`endif

  // TAP next-state logic, straight from the IEEE 1149.1 state diagram.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms_pad_i ? TLR    : RTI;
      RTI:     state_d = tms_pad_i ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_pad_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_pad_i ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_pad_i ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_pad_i ? UPD_DR : PA_DR;
      PA_DR:   state_d = tms_pad_i ? EX2_DR : PA_DR;
      EX2_DR:  state_d = tms_pad_i ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_pad_i ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_pad_i ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_pad_i ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_pad_i ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_pad_i ? UPD_IR : PA_IR;
      PA_IR:   state_d = tms_pad_i ? EX2_IR : PA_IR;
      EX2_IR:  state_d = tms_pad_i ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_pad_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // IR shift path and the active instruction. The active IR is forced to
  // IDCODE on the same edge that enters (or stays in) TLR, so ir_o and the
  // chain selects are already clean when state_o first reads TLR.
  always_comb begin
    ir_shift_d = ir_shift_q;
    if (state_q == CAP_IR) begin
      ir_shift_d = ir_capture;
    end else if (state_q == SH_IR) begin
      ir_shift_d = {tdi_pad_i, ir_shift_q[IR_LEN-1:1]};
    end

    ir_d = ir_q;
    if (state_d == TLR) begin
      ir_d = OP_IDCODE;
    end else if (state_q == UPD_IR) begin
      ir_d = ir_shift_q;
    end
  end

  // Chain selects are decoded from the next instruction and registered on
  // the same edge as ir_o, so the instruction and the one-hot select change
  // together with no decode glitch. Distinct opcodes guarantee one-hot.
  for (genvar gi = 0; gi < N_CHAIN; gi++) begin : g_chain_dec
    localparam logic [IR_LEN-1:0] OP_CHAIN = OP_USER0 + IR_LEN'(gi);
    assign chain_sel_d[gi] = (ir_d == OP_CHAIN);
  end

  assign idcode_sel = (ir_q == OP_IDCODE);

  // Built-in data registers. IDCODE only shifts while it is the selected
  // DR; BYPASS is a single cell that always follows TDI in SH_DR. Both hold
  // their contents through pause states.
  always_comb begin
    idcode_d = idcode_q;
    if (state_q == CAP_DR) begin
      idcode_d = IDCODE_VAL;
    end else if (state_q == SH_DR && idcode_sel) begin
      idcode_d = {tdi_pad_i, idcode_q[31:1]};
    end

    bypass_d = bypass_q;
    if (state_q == CAP_DR) begin
      bypass_d = 1'b0;
    end else if (state_q == SH_DR) begin
      bypass_d = tdi_pad_i;
    end
  end

  // TDO source selection; the result is launched on the falling edge so
  // the probe can sample it on the following rising edge.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_oe_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_oe_d = 1'b1;
      if (idcode_sel) begin
        tdo_d = idcode_q[0];
      end else if (|chain_sel_q) begin
        // AND-OR mux: chain_sel_q is one-hot by construction.
        tdo_d = |(chain_sel_q & chain_tdi_i);
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  // Rising-edge state: FSM, IR, active instruction, selects and DRs.
  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      state_q     <= TLR;
      ir_shift_q  <= '0;
      ir_q        <= OP_IDCODE;
      chain_sel_q <= '0;
      idcode_q    <= IDCODE_VAL;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_shift_q  <= ir_shift_d;
      ir_q        <= ir_d;
      chain_sel_q <= chain_sel_d;
      idcode_q    <= idcode_d;
      bypass_q    <= bypass_d;
    end
  end

  // Falling-edge TDO and output-enable flops; also cleared by TRST.
  always_ff @(negedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo_pad_o   = tdo_q;
  assign tdo_padoe_o = tdo_oe_q;
  assign tdo_o       = tdi_pad_i;
  assign chain_sel_o = chain_sel_q;
  assign ir_o        = ir_q;
  assign state_o     = state_q;

  assign test_logic_reset_o = (state_q == TLR);
  assign run_test_idle_o    = (state_q == RTI);
  assign capture_dr_o       = (state_q == CAP_DR);
  assign shift_dr_o         = (state_q == SH_DR);
  assign pause_dr_o         = (state_q == PA_DR);
  assign update_dr_o        = (state_q == UPD_DR);

endmodule

// File: tb/tb_jtag_tap_gen.sv
// Testbench for jtag_tap_gen: directed TAP sequences with hand-computed
// state / TDO / output-enable / instruction expectations.
module tb_jtag_tap_gen;

  logic       tck = 1'b0;
  logic       trst = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic [3:0] chain_tdi = 4'h0;

  logic       tdo_pad, tdo_padoe, tdo_out;
  logic [3:0] chain_sel;
  logic [4:0] ir;
  logic [3:0] state;
  logic       tlr_o, rti_o, cap_dr_o, sh_dr_o, pa_dr_o, upd_dr_o;
`ifdef JTAG_TAP_IR_STATUS_EN
  logic [2:0] ir_status = 3'b000;
`endif

  jtag_tap_gen dut (
    .tck_pad_i          (tck),
    .trst_pad_i         (trst),
    .tms_pad_i          (tms),
    .tdi_pad_i          (tdi),
    .tdo_pad_o          (tdo_pad),
    .tdo_padoe_o        (tdo_padoe),
    .tdo_o              (tdo_out),
    .chain_tdi_i        (chain_tdi),
    .chain_sel_o        (chain_sel),
    .ir_o               (ir),
    .state_o            (state),
    .test_logic_reset_o (tlr_o),
    .run_test_idle_o    (rti_o),
    .capture_dr_o       (cap_dr_o),
    .shift_dr_o         (sh_dr_o),
    .pause_dr_o         (pa_dr_o),
    .update_dr_o        (upd_dr_o)
`ifdef JTAG_TAP_IR_STATUS_EN
    ,
    .ir_status_i        (ir_status)
`endif
  );

  always #5 tck = ~tck;

  int n_tests = 0;
  int n_fail  = 0;

  // Watches for any update_dr pulse while armed (around the TRST abort).
  logic mon_armed = 1'b0;
  logic upd_seen  = 1'b0;
  always @(posedge upd_dr_o) if (mon_armed) upd_seen = 1'b1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One TCK cycle: drive inputs, check state after the rising edge, then
  // check TDO/OE after the falling edge that launches them.
  task automatic step(input logic t_ms, input logic t_di, input logic [3:0] c,
                      input logic [3:0] est, input logic etdo, input logic eoe,
                      input string name);
    tms = t_ms;
    tdi = t_di;
    chain_tdi = c;
    @(posedge tck);
    #1;
    chk({name, ".state"}, 32'(state), 32'(est));
    @(negedge tck);
    #1;
    chk({name, ".tdo"}, 32'(tdo_pad), 32'(etdo));
    chk({name, ".oe"}, 32'(tdo_padoe), 32'(eoe));
    $display("[TB] %s tms=%0b tdi=%0b state=%h tdo=%0b oe=%0b ir=%h sel=%b",
             name, t_ms, t_di, state, tdo_pad, tdo_padoe, ir, chain_sel);
  endtask

  task automatic do_reset();
    @(negedge tck);
    #1;
    tms  = 1'b1;
    tdi  = 1'b0;
    trst = 1'b1;
    #2;
    trst = 1'b0;
  endtask

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] ctdi;
    logic [3:0] st;
    logic       tdo;
    logic       oe;
    logic [4:0] ir;
    logic [3:0] sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a_tms, input logic a_tdi, input logic [3:0] a_c,
                     input logic [3:0] a_st, input logic a_tdo, input logic a_oe,
                     input logic [4:0] a_ir, input logic [3:0] a_sel);
    vec_t v;
    v.tms = a_tms; v.tdi = a_tdi; v.ctdi = a_c; v.st = a_st;
    v.tdo = a_tdo; v.oe = a_oe; v.ir = a_ir; v.sel = a_sel;
    vecs.push_back(v);
  endtask

  logic [31:0] idv;
  logic [31:0] got;
  logic [4:0]  irg;

  initial begin
    idv = 32'h149511c3;

    // Vector table, starting from TLR with ir_o = IDCODE.
    // IR scan of 0x1F: capture reads 1,0,0,0,0.
    add(0,0,4'h0, 4'hC,0,0, 5'h01,4'h0);
    add(1,0,4'h0, 4'h7,0,0, 5'h01,4'h0);
    add(1,0,4'h0, 4'h4,0,0, 5'h01,4'h0);
    add(0,0,4'h0, 4'hE,0,0, 5'h01,4'h0);
    add(0,0,4'h0, 4'hA,1,1, 5'h01,4'h0);
    add(0,1,4'h0, 4'hA,0,1, 5'h01,4'h0);
    add(0,1,4'h0, 4'hA,0,1, 5'h01,4'h0);
    add(0,1,4'h0, 4'hA,0,1, 5'h01,4'h0);
    add(0,1,4'h0, 4'hA,0,1, 5'h01,4'h0);
    add(1,1,4'h0, 4'h9,0,0, 5'h01,4'h0);
    add(1,0,4'h0, 4'hD,0,0, 5'h01,4'h0);
    add(0,0,4'h0, 4'hC,0,0, 5'h1F,4'h0);
    // BYPASS DR scan: TDI 1,0,1,1 returns 0,1,0,1.
    add(1,0,4'h0, 4'h7,0,0, 5'h1F,4'h0);
    add(0,0,4'h0, 4'h6,0,0, 5'h1F,4'h0);
    add(0,0,4'h0, 4'h2,0,1, 5'h1F,4'h0);
    add(0,1,4'h0, 4'h2,1,1, 5'h1F,4'h0);
    add(0,0,4'h0, 4'h2,0,1, 5'h1F,4'h0);
    add(0,1,4'h0, 4'h2,1,1, 5'h1F,4'h0);
    add(1,1,4'h0, 4'h1,0,0, 5'h1F,4'h0);
    add(1,0,4'h0, 4'h5,0,0, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hC,0,0, 5'h1F,4'h0);
    // IR scan of 0x12 (LSB first 0,1,0,0,1) selects user chain 2.
    add(1,0,4'h0, 4'h7,0,0, 5'h1F,4'h0);
    add(1,0,4'h0, 4'h4,0,0, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hE,0,0, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hA,1,1, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hA,0,1, 5'h1F,4'h0);
    add(0,1,4'h0, 4'hA,0,1, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hA,0,1, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hA,0,1, 5'h1F,4'h0);
    add(1,1,4'h0, 4'h9,0,0, 5'h1F,4'h0);
    add(1,0,4'h0, 4'hD,0,0, 5'h1F,4'h0);
    add(0,0,4'h0, 4'hC,0,0, 5'h12,4'h4);
    // DR scan through chain 2: TDO mirrors chain_tdi[2], other bits ignored.
    add(1,0,4'h0, 4'h7,0,0, 5'h12,4'h4);
    add(0,0,4'h0, 4'h6,0,0, 5'h12,4'h4);
    add(0,0,4'h4, 4'h2,1,1, 5'h12,4'h4);
    add(0,0,4'h1, 4'h2,0,1, 5'h12,4'h4);
    add(0,0,4'h5, 4'h2,1,1, 5'h12,4'h4);
    add(0,0,4'hB, 4'h2,0,1, 5'h12,4'h4);
    // Five TMS=1 clocks from SH_DR reach TLR and restore IDCODE.
    add(1,0,4'h0, 4'h1,0,0, 5'h12,4'h4);
    add(1,0,4'h0, 4'h5,0,0, 5'h12,4'h4);
    add(1,0,4'h0, 4'h7,0,0, 5'h12,4'h4);
    add(1,0,4'h0, 4'h4,0,0, 5'h12,4'h4);
    add(1,0,4'h0, 4'hF,0,0, 5'h01,4'h0);

    // ---- Reset state ----
    do_reset();
    #1;
    chk("rst.state", 32'(state), 32'hF);
    chk("rst.tlr", 32'(tlr_o), 32'd1);
    chk("rst.strobes", 32'({rti_o, cap_dr_o, sh_dr_o, pa_dr_o, upd_dr_o}), 32'd0);
    chk("rst.ir", 32'(ir), 32'h01);
    chk("rst.sel", 32'(chain_sel), 32'h0);
    chk("rst.tdo", 32'(tdo_pad), 32'd0);
    chk("rst.oe", 32'(tdo_padoe), 32'd0);
    tdi = 1'b1;
    #1;
    chk("tdo_o.follow", 32'(tdo_out), 32'd1);
    tdi = 1'b0;
    $display("[TB] reset state=%h ir=%h sel=%b", state, ir, chain_sel);

    // ---- IDCODE read: TMS 0,1,0,0 then 32 shift clocks ----
    step(0, 0, 4'h0, 4'hC, 0, 0, "id.rti");
    chk("id.rti_o", 32'(rti_o), 32'd1);
    step(1, 0, 4'h0, 4'h7, 0, 0, "id.seldr");
    step(0, 0, 4'h0, 4'h6, 0, 0, "id.capdr");
    chk("id.capture_dr_o", 32'(cap_dr_o), 32'd1);
    step(0, 0, 4'h0, 4'h2, idv[0], 1, "id.bit0");
    got = '0;
    got[0] = tdo_pad;
    for (int i = 1; i < 32; i++) begin
      step(0, 0, 4'h0, 4'h2, idv[i], 1, $sformatf("id.bit%0d", i));
      got[i] = tdo_pad;
    end
    chk("id.word", got, idv);
    chk("id.shift_dr_o", 32'(sh_dr_o), 32'd1);
    step(1, 0, 4'h0, 4'h1, 0, 0, "id.ex1");
    step(1, 0, 4'h0, 4'h5, 0, 0, "id.upd");
    chk("id.update_dr_o", 32'(upd_dr_o), 32'd1);
    step(1, 0, 4'h0, 4'h7, 0, 0, "id.seldr2");
    step(1, 0, 4'h0, 4'h4, 0, 0, "id.selir");
    step(1, 0, 4'h0, 4'hF, 0, 0, "id.tlr");

    // ---- Table-driven IR / BYPASS / chain / TLR sequence ----
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tms, vecs[i].tdi, vecs[i].ctdi, vecs[i].st, vecs[i].tdo,
           vecs[i].oe, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.ir", i), 32'(ir), 32'(vecs[i].ir));
      chk($sformatf("vec%0d.sel", i), 32'(chain_sel), 32'(vecs[i].sel));
    end
    chain_tdi = 4'h0;

    // ---- IDCODE shift with pause and resume, then TRST at bit 10 ----
    step(0, 0, 4'h0, 4'hC, 0, 0, "pz.rti");
    step(1, 0, 4'h0, 4'h7, 0, 0, "pz.seldr");
    step(0, 0, 4'h0, 4'h6, 0, 0, "pz.capdr");
    step(0, 0, 4'h0, 4'h2, idv[0], 1, "pz.bit0");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 4'h0, 4'h2, idv[i], 1, $sformatf("pz.bit%0d", i));
    step(1, 0, 4'h0, 4'h1, 0, 0, "pz.ex1");
    step(0, 0, 4'h0, 4'h3, 0, 0, "pz.pause0");
    chk("pz.pause_dr_o", 32'(pa_dr_o), 32'd1);
    step(0, 0, 4'h0, 4'h3, 0, 0, "pz.pause1");
    step(1, 0, 4'h0, 4'h0, 0, 0, "pz.ex2");
    for (int i = 6; i <= 10; i++)
      step(0, 0, 4'h0, 4'h2, idv[i], 1, $sformatf("pz.bit%0d", i));

    mon_armed = 1'b1;
    upd_seen  = 1'b0;
    tms = 1'b1;
    #2;
    trst = 1'b1;
    #1;
    chk("trst.state", 32'(state), 32'hF);
    chk("trst.tlr", 32'(tlr_o), 32'd1);
    chk("trst.tdo", 32'(tdo_pad), 32'd0);
    chk("trst.oe", 32'(tdo_padoe), 32'd0);
    chk("trst.ir", 32'(ir), 32'h01);
    $display("[TB] trst mid-shift state=%h tdo=%0b oe=%0b", state, tdo_pad, tdo_padoe);
    @(negedge tck);
    #1;
    trst = 1'b0;
    step(1, 0, 4'h0, 4'hF, 0, 0, "trst.hold0");
    step(1, 0, 4'h0, 4'hF, 0, 0, "trst.hold1");
    chk("trst.no_update", 32'(upd_seen), 32'd0);
    mon_armed = 1'b0;

    // IDCODE DR was restored by TRST: a fresh scan starts at bit 0.
    step(0, 0, 4'h0, 4'hC, 0, 0, "rs.rti");
    step(1, 0, 4'h0, 4'h7, 0, 0, "rs.seldr");
    step(0, 0, 4'h0, 4'h6, 0, 0, "rs.capdr");
    step(0, 0, 4'h0, 4'h2, idv[0], 1, "rs.bit0");
    step(0, 0, 4'h0, 4'h2, idv[1], 1, "rs.bit1");
    step(0, 0, 4'h0, 4'h2, idv[2], 1, "rs.bit2");
    step(1, 0, 4'h0, 4'h1, 0, 0, "rs.ex1");
    step(1, 0, 4'h0, 4'h5, 0, 0, "rs.upd");
    step(1, 0, 4'h0, 4'h7, 0, 0, "rs.seldr2");
    step(1, 0, 4'h0, 4'h4, 0, 0, "rs.selir");
    step(1, 0, 4'h0, 4'hF, 0, 0, "rs.tlr");

`ifdef JTAG_TAP_IR_STATUS_EN
    // ---- IR capture with status bits 3'b101 reads 0b10101 ----
    ir_status = 3'b101;
    step(0, 0, 4'h0, 4'hC, 0, 0, "st.rti");
    step(1, 0, 4'h0, 4'h7, 0, 0, "st.seldr");
    step(1, 0, 4'h0, 4'h4, 0, 0, "st.selir");
    step(0, 0, 4'h0, 4'hE, 0, 0, "st.capir");
    step(0, 0, 4'h0, 4'hA, 1, 1, "st.b0");
    irg = '0;
    irg[0] = tdo_pad;
    step(0, 0, 4'h0, 4'hA, 0, 1, "st.b1");
    irg[1] = tdo_pad;
    step(0, 0, 4'h0, 4'hA, 1, 1, "st.b2");
    irg[2] = tdo_pad;
    step(0, 0, 4'h0, 4'hA, 0, 1, "st.b3");
    irg[3] = tdo_pad;
    step(0, 0, 4'h0, 4'hA, 1, 1, "st.b4");
    irg[4] = tdo_pad;
    chk("st.capture", 32'(irg), 32'h15);
    step(1, 0, 4'h0, 4'h9, 0, 0, "st.ex1");
    step(1, 0, 4'h0, 4'hD, 0, 0, "st.upd");
    step(1, 0, 4'h0, 4'h7, 0, 0, "st.seldr2");
    step(1, 0, 4'h0, 4'h4, 0, 0, "st.selir2");
    step(1, 0, 4'h0, 4'hF, 0, 0, "st.tlr");
`else
    irg = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
